reuleaux_engine: RTL

//  Parametrised shape rasteriser for the VGA framebuffer path: circle, Reuleaux triangle or full-screen clear.

---
 rtl/reuleaux_engine_if.sv | 23 ++
 rtl/reuleaux_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reuleaux_engine_if.sv
// rtl/reuleaux_engine_if.sv - pixel write port between the shape rasteriser and the VGA adapter
//
// Purpose: carries one candidate pixel at a time from the engine to the framebuffer sink.
//   A pixel transfers on a rising clock edge where vga_plot && vga_ready.
// Signals:
//   vga_x      X_W  pixel column         (engine -> sink)
//   vga_y      Y_W  pixel row            (engine -> sink)
//   vga_colour 3    pixel colour         (engine -> sink)
//   vga_plot   1    pixel valid          (engine -> sink)
//   vga_ready  1    sink accepts a pixel (sink -> engine)
interface reuleaux_engine_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) ();
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           vga_ready;

  modport master (output vga_x, output vga_y, output vga_colour, output vga_plot, input vga_ready);
  modport slave  (input vga_x, input vga_y, input vga_colour, input vga_plot, output vga_ready);
endinterface

// File: rtl/reuleaux_engine.sv
// rtl/reuleaux_engine.sv - midpoint-circle shape rasteriser: circle, Reuleaux triangle, screen clear
//
// Purpose: walks midpoint-circle octants and emits one clipped pixel per accepted handshake.
//   mode 0 circle, 1 Reuleaux triangle (three filtered arcs), 2 raster clear, 3 reserved (no plots).
// Optional feature macro: REULEAUX_ENGINE_CLEAR_EN enables the mode 2 raster clear; without it
//   mode 2 finishes immediately with zero plots, like mode 3.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   colour, centre_x/y  draw colour and shape centre, sampled when the draw starts
//   radius, mode        circle radius / Reuleaux diameter and shape select, sampled at start
//   start, done         level request; done holds high until start drops
//   vga                 pixel write port (master side)
module reuleaux_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [2:0]     colour,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [X_W-1:0] radius,
  input  logic [1:0]     mode,
  input  logic           start,
  output logic           done,
  reuleaux_engine_if.master vga
);
  localparam int W  = X_W + 2;   // signed coordinate width
  localparam int DW = 2 * W;     // squared distance width
  localparam int CW = W + 2;     // decision variable width
  localparam int KW = X_W + 16;  // corner offset product width
  localparam logic signed [W-1:0]  SW_S  = W'(SCREEN_W);
  localparam logic signed [W-1:0]  SH_S  = W'(SCREEN_H);
  localparam logic signed [W-1:0]  W_ONE = W'(1);
  localparam logic signed [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_OCT, ST_STEP, ST_NEXT_ARC, ST_DONE
`ifdef REULEAUX_ENGINE_CLEAR_EN
    , ST_CLEAR
`endif
  } state_t;

  state_t                state;
  logic [1:0]            mode_r;
  logic [2:0]            colour_r;
  logic signed [W-1:0]   d_r, ax, ay, x_r, y_r;
  logic signed [CW-1:0]  crit_r;
  logic [2:0]            oct;
  logic [1:0]            arc;
  logic signed [W-1:0]   c_x [3];
  logic signed [W-1:0]   c_y [3];
`ifdef REULEAUX_ENGINE_CLEAR_EN
  logic [X_W-1:0]        clr_x;
  logic [Y_W-1:0]        clr_y;
`endif

  function automatic logic signed [CW-1:0] ext(input logic signed [W-1:0] v);
    return {{2{v[W-1]}}, v};
  endfunction

  function automatic logic signed [DW-1:0] sq(input logic signed [W-1:0] v);
    logic signed [DW-1:0] e;
    e = {{W{v[W-1]}}, v};
    return e * e;
  endfunction

  // Corner geometry from the raw inputs; only captured in INIT.
  logic [KW-1:0]       k_prod1, k_prod2;
  logic [X_W-1:0]      k1, k2;
  logic signed [W-1:0] in_cx, in_cy, in_d, half_d, c1_x, c2_x, c12_y, c3_y;
  assign k_prod1 = KW'(radius) * KW'(18918);
  assign k_prod2 = KW'(radius) * KW'(37837);
  assign k1      = X_W'(k_prod1 >> 16);
  assign k2      = X_W'(k_prod2 >> 16);
  assign in_cx   = {2'b00, centre_x};
  assign in_cy   = {{(W-Y_W){1'b0}}, centre_y};
  assign in_d    = {2'b00, radius};
  assign half_d  = {3'b000, radius[X_W-1:1]};
  assign c1_x    = in_cx + half_d;
  assign c2_x    = in_cx - half_d;
  assign c12_y   = in_cy + {2'b00, k1};
  assign c3_y    = in_cy - {2'b00, k2};

  // Candidate pixel for the current octant, clip and Reuleaux intersection filter.
  logic signed [W-1:0]  off_x, off_y, cand_x, cand_y;
  logic [1:0]           oa, ob;
  logic signed [DW-1:0] dist_a, dist_b, d_sq;
  logic                 on_screen, cand_ok;
  always_comb begin
    off_x = x_r;
    off_y = y_r;
    case (oct)
      3'd0: begin off_x = x_r;  off_y = y_r;  end
      3'd1: begin off_x = y_r;  off_y = x_r;  end
      3'd2: begin off_x = -y_r; off_y = x_r;  end
      3'd3: begin off_x = -x_r; off_y = y_r;  end
      3'd4: begin off_x = -x_r; off_y = -y_r; end
      3'd5: begin off_x = -y_r; off_y = -x_r; end
      3'd6: begin off_x = y_r;  off_y = -x_r; end
      default: begin off_x = x_r; off_y = -y_r; end
    endcase
    cand_x = ax + off_x;
    cand_y = ay + off_y;
    on_screen = !cand_x[W-1] && (cand_x < SW_S) && !cand_y[W-1] && (cand_y < SH_S);
    oa = 2'd1;
    ob = 2'd2;
    case (arc)
      2'd0:    begin oa = 2'd1; ob = 2'd2; end
      2'd1:    begin oa = 2'd0; ob = 2'd2; end
      default: begin oa = 2'd0; ob = 2'd1; end
    endcase
    dist_a  = sq(cand_x - c_x[oa]) + sq(cand_y - c_y[oa]);
    dist_b  = sq(cand_x - c_x[ob]) + sq(cand_y - c_y[ob]);
    d_sq    = sq(d_r);
    cand_ok = on_screen && ((mode_r != 2'd1) || ((dist_a <= d_sq) && (dist_b <= d_sq)));
  end

  // Midpoint step: y advances every step, x only when the decision variable goes positive.
  logic signed [W-1:0]  y_nx, x_nx;
  logic signed [CW-1:0] crit_nx;
  always_comb begin
    y_nx = y_r + W_ONE;
    x_nx = x_r;
    crit_nx = crit_r;
    if (crit_r <= 0) begin
      crit_nx = crit_r + (ext(y_nx) <<< 1) + C_ONE;
    end else begin
      x_nx = x_r - W_ONE;
      crit_nx = crit_r + ((ext(y_nx) - ext(x_nx)) <<< 1) + C_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      done           <= 1'b0;
      vga.vga_plot   <= 1'b0;
      vga.vga_x      <= '0;
      vga.vga_y      <= '0;
      vga.vga_colour <= '0;
      mode_r         <= '0;
      colour_r       <= '0;
      d_r            <= '0;
      ax             <= '0;
      ay             <= '0;
      x_r            <= '0;
      y_r            <= '0;
      crit_r         <= '0;
      oct            <= '0;
      arc            <= '0;
      for (int i = 0; i < 3; i++) begin
        c_x[i] <= '0;
        c_y[i] <= '0;
      end
`ifdef REULEAUX_ENGINE_CLEAR_EN
      clr_x          <= '0;
      clr_y          <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_INIT;
        ST_INIT: begin
          mode_r   <= mode;
          colour_r <= colour;
          d_r      <= in_d;
          c_x[0] <= c1_x;  c_y[0] <= c12_y;
          c_x[1] <= c2_x;  c_y[1] <= c12_y;
          c_x[2] <= in_cx; c_y[2] <= c3_y;
          ax     <= (mode == 2'd1) ? c1_x : in_cx;
          ay     <= (mode == 2'd1) ? c12_y : in_cy;
          x_r    <= in_d;
          y_r    <= '0;
          crit_r <= C_ONE - ext(in_d);
          oct    <= '0;
          arc    <= '0;
          if (mode == 2'd0 || mode == 2'd1) state <= ST_OCT;
`ifdef REULEAUX_ENGINE_CLEAR_EN
          else if (mode == 2'd2) begin
            clr_x <= '0;
            clr_y <= '0;
            state <= ST_CLEAR;
          end
`endif
          else state <= ST_DONE;
        end
        ST_OCT: begin
          if (vga.vga_plot) begin
            if (vga.vga_ready) begin
              vga.vga_plot <= 1'b0;
              oct <= oct + 3'd1;
              if (oct == 3'd7) state <= ST_STEP;
            end
          end else if (cand_ok) begin
            vga.vga_plot   <= 1'b1;
            vga.vga_x      <= cand_x[X_W-1:0];
            vga.vga_y      <= cand_y[Y_W-1:0];
            vga.vga_colour <= colour_r;
          end else begin
            oct <= oct + 3'd1;
            if (oct == 3'd7) state <= ST_STEP;
          end
        end
        ST_STEP: begin
          y_r    <= y_nx;
          x_r    <= x_nx;
          crit_r <= crit_nx;
          state  <= (y_nx > x_nx) ? ST_NEXT_ARC : ST_OCT;
        end
        ST_NEXT_ARC: begin
          if (mode_r == 2'd1 && arc != 2'd2) begin
            arc    <= arc + 2'd1;
            ax     <= c_x[arc + 2'd1];
            ay     <= c_y[arc + 2'd1];
            x_r    <= d_r;
            y_r    <= '0;
            crit_r <= C_ONE - ext(d_r);
            state  <= ST_OCT;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          if (!start && done) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
`ifdef REULEAUX_ENGINE_CLEAR_EN
        ST_CLEAR: begin
          if (vga.vga_plot) begin
            if (vga.vga_ready) begin
              vga.vga_plot <= 1'b0;
              if (clr_x == X_W'(SCREEN_W - 1)) begin
                clr_x <= '0;
                if (clr_y == Y_W'(SCREEN_H - 1)) state <= ST_DONE;
                else clr_y <= clr_y + 1'b1;
              end else begin
                clr_x <= clr_x + 1'b1;
              end
            end
          end else begin
            vga.vga_plot   <= 1'b1;
            vga.vga_x      <= clr_x;
            vga.vga_y      <= clr_y;
            vga.vga_colour <= colour_r;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
